// File: rtl/byte_calc_core.sv
// Byte-stream calculator: takes operand A, operand B and an operator byte, shows the
// 5-bit sum/difference on the LEDs and replies with it as ASCII hex over the strobe interface.
module byte_calc_core #(
   parameter logic       CR_EN    = 1'b1,
   parameter logic [7:0] ERR_CHAR = 8'h3F
) (
   input  logic       clk12m,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_data_rdy,
   output logic [7:0] tx_data,
   output logic       tx_data_rdy,
   input  logic       tx_busy,
   output logic [4:0] leds,
   output logic       rx_overrun
);

   typedef enum logic [2:0] {S_A, S_B, S_OP, S_TX0, S_TX1, S_TXCR, S_ERR} state_t;

   state_t     state, state_nx;
   logic [3:0] opa, opa_nx, opb, opb_nx;
   logic [4:0] res, res_nx, leds_nx;
   logic [7:0] tx_data_nx;
   logic       tx_rdy_nx, ovr_nx;
   logic       can_send;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // A strobe in the previous cycle forces one idle cycle before tx_busy is trusted again.
   assign can_send = !tx_data_rdy && !tx_busy;

   always_comb begin
      state_nx   = state;
      opa_nx     = opa;
      opb_nx     = opb;
      res_nx     = res;
      leds_nx    = leds;
      tx_data_nx = 8'h00;
      tx_rdy_nx  = 1'b0;
      ovr_nx     = 1'b0;
      case (state)
         S_A: if (rx_data_rdy) begin
            if (rx_data[7:4] == 4'h0) begin
               opa_nx   = rx_data[3:0];
               state_nx = S_B;
            end else begin
               state_nx = S_ERR;
            end
         end
         S_B: if (rx_data_rdy) begin
            if (rx_data[7:4] == 4'h0) begin
               opb_nx   = rx_data[3:0];
               state_nx = S_OP;
            end else begin
               state_nx = S_ERR;
            end
         end
         S_OP: if (rx_data_rdy) begin
            case (rx_data)
               8'h2B: begin
                  res_nx   = {1'b0, opa} + {1'b0, opb};
                  state_nx = S_TX0;
               end
               8'h2D: begin
                  res_nx   = {1'b0, opa} - {1'b0, opb};
                  state_nx = S_TX0;
               end
               default: state_nx = S_ERR;
            endcase
         end
         S_TX0: begin
            // LEDs follow the result one cycle after the operator is accepted.
            leds_nx = res;
            ovr_nx  = rx_data_rdy;
            if (can_send) begin
               tx_rdy_nx  = 1'b1;
               tx_data_nx = res[4] ? 8'h31 : 8'h30;
               state_nx   = S_TX1;
            end
         end
         S_TX1: begin
            ovr_nx = rx_data_rdy;
            if (can_send) begin
               tx_rdy_nx  = 1'b1;
               tx_data_nx = hex_char(res[3:0]);
               state_nx   = CR_EN ? S_TXCR : S_A;
            end
         end
         S_TXCR: begin
            ovr_nx = rx_data_rdy;
            if (can_send) begin
               tx_rdy_nx  = 1'b1;
               tx_data_nx = 8'h0D;
               state_nx   = S_A;
            end
         end
         S_ERR: begin
            ovr_nx = rx_data_rdy;
            if (can_send) begin
               tx_rdy_nx  = 1'b1;
               tx_data_nx = ERR_CHAR;
               state_nx   = S_A;
            end
         end
         default: state_nx = S_A;
      endcase
   end

   always_ff @(posedge clk12m) begin
      if (rst) begin
         state       <= S_A;
         opa         <= 4'h0;
         opb         <= 4'h0;
         res         <= 5'h00;
         leds        <= 5'h00;
         tx_data     <= 8'h00;
         tx_data_rdy <= 1'b0;
         rx_overrun  <= 1'b0;
      end else begin
         state       <= state_nx;
         opa         <= opa_nx;
         opb         <= opb_nx;
         res         <= res_nx;
         leds        <= leds_nx;
         tx_data     <= tx_data_nx;
         tx_data_rdy <= tx_rdy_nx;
         rx_overrun  <= ovr_nx;
      end
   end

endmodule

// File: tb/tb_byte_calc_core.sv
// Self-checking bench for byte_calc_core: fixed vector table, busy/overrun/reset
// sequences, and randomized commands checked against an arithmetic reply model.
module tb_byte_calc_core;

   logic       clk12m = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_data_rdy = 1'b0;
   logic [7:0] tx_data;
   logic       tx_data_rdy;
   logic       tx_busy;
   logic [4:0] leds;
   logic       rx_overrun;

   byte_calc_core dut (
      .clk12m(clk12m), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
      .tx_data(tx_data), .tx_data_rdy(tx_data_rdy), .tx_busy(tx_busy),
      .leds(leds), .rx_overrun(rx_overrun)
   );

   always #5 clk12m = ~clk12m;

   typedef struct {
      int unsigned     n;
      logic [2:0][7:0] b;
      logic [4:0]      leds;
      int unsigned     rlen;
      logic [2:0][7:0] r;
   } vec_t;

   int total = 0;
   int bad = 0;

   // Monitor / late-transmitter state
   logic [7:0] got_q[$];
   int  gap_viol = 0, busy_viol = 0, idle_viol = 0, ovr_cnt = 0, ovr_long = 0;
   logic prev_rdy = 1'b0, prev_ovr = 1'b0, pend = 1'b0;
   logic busy_force = 1'b0, rnd_en = 1'b0;
   int  busy_cnt = 0;
   logic [4:0] cur_leds = 5'h00;
   string HEX = "0123456789ABCDEF";

   assign tx_busy = busy_force | (busy_cnt != 0);

   always @(negedge clk12m) begin
      if (tx_data_rdy) begin
         got_q.push_back(tx_data);
         if (prev_rdy) gap_viol++;
         if (tx_busy) busy_viol++;
      end else if (tx_data != 8'h00) begin
         idle_viol++;
      end
      if (rx_overrun) begin
         ovr_cnt++;
         if (prev_ovr) ovr_long++;
      end
      prev_rdy = tx_data_rdy;
      prev_ovr = rx_overrun;
      // Transmitter that raises busy one cycle after it sees a strobe.
      if (busy_cnt != 0) busy_cnt--;
      if (pend) begin
         busy_cnt = $urandom_range(0, 6);
         pend = 1'b0;
      end
      if (tx_data_rdy && rnd_en) pend = 1'b1;
   end

   task automatic tick;
      @(posedge clk12m);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_data_rdy = 1'b1;
      tick;
      rx_data_rdy = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic wait_q(input int n, input int budget, input string nm);
      int k = 0;
      while (got_q.size() < n && k < budget) begin
         tick;
         k++;
      end
      chk({nm, "_reply_in_time"}, 32'(got_q.size() >= n), 32'd1);
   endtask

   function automatic vec_t mk(input int unsigned n, input logic [7:0] b0, b1, b2,
                               input logic [4:0] l, input int unsigned rl,
                               input logic [7:0] r0, r1, r2);
      vec_t v;
      v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
      v.leds = l; v.rlen = rl; v.r[0] = r0; v.r[1] = r1; v.r[2] = r2;
      return v;
   endfunction

   // Reference: reply and LED value from the command rules, using plain arithmetic.
   function automatic vec_t model(input logic [7:0] a, b, op, input logic [4:0] prev);
      vec_t v;
      int r;
      if (a > 15)                        v = mk(1, a, 0, 0, prev, 1, "?", 0, 0);
      else if (b > 15)                   v = mk(2, a, b, 0, prev, 1, "?", 0, 0);
      else if (op != "+" && op != "-")   v = mk(3, a, b, op, prev, 1, "?", 0, 0);
      else begin
         r = (op == "+") ? int'(a) + int'(b) : int'(a) - int'(b);
         r = (r + 32) % 32;
         v = mk(3, a, b, op, 5'(r), 3, (r >= 16) ? "1" : "0", HEX[r % 16], 8'h0D);
      end
      return v;
   endfunction

   task automatic apply_vec(input vec_t v, input string tag);
      got_q.delete();
      for (int i = 0; i < int'(v.n); i++) send_byte(v.b[i]);
      chk({tag, "_leds_before_update"}, leds, cur_leds);
      tick;
      chk({tag, "_leds"}, leds, v.leds);
      if (!rnd_en) chk({tag, "_first_strobe"}, tx_data_rdy, 1'b1);
      wait_q(int'(v.rlen), 300, tag);
      repeat (8) tick;
      chk({tag, "_reply_len"}, got_q.size(), v.rlen);
      for (int i = 0; i < int'(v.rlen) && i < got_q.size(); i++)
         chk($sformatf("%s_char%0d", tag, i), got_q[i], v.r[i]);
      cur_leds = v.leds;
   endtask

   vec_t vt[12];
   logic [7:0] ra, rb, rop;

   initial begin
      vt[0]  = mk(3, 4, 3, "+", 5'h07, 3, "0", "7", 8'h0D);
      vt[1]  = mk(3, 4, 4, "+", 5'h08, 3, "0", "8", 8'h0D);
      vt[2]  = mk(3, 4, 5, "+", 5'h09, 3, "0", "9", 8'h0D);
      vt[3]  = mk(3, 15, 1, "+", 5'h10, 3, "1", "0", 8'h0D);
      vt[4]  = mk(3, 3, 4, "-", 5'h1F, 3, "1", "F", 8'h0D);
      vt[5]  = mk(3, 9, 9, "-", 5'h00, 3, "0", "0", 8'h0D);
      vt[6]  = mk(3, 4, 3, "*", 5'h00, 1, "?", 0, 0);
      vt[7]  = mk(3, 2, 2, "+", 5'h04, 3, "0", "4", 8'h0D);
      vt[8]  = mk(1, 20, 0, 0, 5'h04, 1, "?", 0, 0);
      vt[9]  = mk(3, 15, 15, "+", 5'h1E, 3, "1", "E", 8'h0D);
      vt[10] = mk(3, 0, 15, "-", 5'h11, 3, "1", "1", 8'h0D);
      vt[11] = mk(2, 5, 16, 0, 5'h11, 1, "?", 0, 0);

      repeat (3) tick;
      chk("reset_leds", leds, 5'h00);
      chk("reset_tx_data", tx_data, 8'h00);
      chk("reset_tx_rdy", tx_data_rdy, 1'b0);
      chk("reset_overrun", rx_overrun, 1'b0);
      rst = 1'b0;
      repeat (2) tick;

      for (int i = 0; i < 12; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

      // Transmitter busy for a long stretch, plus a byte dropped mid-reply.
      got_q.delete();
      busy_force = 1'b1;
      send_byte(1); send_byte(1); send_byte("+");
      tick;
      chk("busy_leds", leds, 5'h02);
      repeat (50) tick;
      chk("busy_no_strobe", got_q.size(), 0);
      busy_force = 1'b0;
      wait_q(1, 20, "busy_first");
      send_byte(8'h05);
      wait_q(3, 40, "busy_rest");
      repeat (6) tick;
      chk("busy_reply_len", got_q.size(), 3);
      if (got_q.size() >= 3) begin
         chk("busy_char0", got_q[0], "0");
         chk("busy_char1", got_q[1], "2");
         chk("busy_char2", got_q[2], 8'h0D);
      end
      chk("overrun_pulses", ovr_cnt, 1);
      cur_leds = 5'h02;
      apply_vec(mk(3, 6, 1, "-", 5'h05, 3, "0", "5", 8'h0D), "after_drop");

      // Reset mid-command, then mid-reply.
      send_byte(7);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rst_cmd_tx_rdy", tx_data_rdy, 1'b0);
      chk("rst_cmd_leds", leds, 5'h00);
      got_q.delete();
      send_byte(8); send_byte(8); send_byte("+");
      wait_q(1, 20, "rst_reply");
      chk("rst_pre_leds", leds, 5'h10);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rst_reply_tx_rdy", tx_data_rdy, 1'b0);
      chk("rst_reply_tx_data", tx_data, 8'h00);
      chk("rst_reply_leds", leds, 5'h00);
      repeat (20) tick;
      chk("rst_abandoned_reply", got_q.size(), 1);
      cur_leds = 5'h00;
      apply_vec(mk(3, 1, 2, "+", 5'h03, 3, "0", "3", 8'h0D), "after_rst");

      // Randomized commands with a randomly busy, late-responding transmitter.
      rnd_en = 1'b1;
      for (int t = 0; t < 40; t++) begin
         ra  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
         rb  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: rop = "+";
            5, 6, 7, 8:    rop = "-";
            default: begin
               rop = 8'($urandom);
               if (rop == "+" || rop == "-") rop = "*";
            end
         endcase
         apply_vec(model(ra, rb, rop, cur_leds), $sformatf("rnd%0d", t));
      end
      rnd_en = 1'b0;
      repeat (10) tick;

      chk("no_back_to_back_strobes", gap_viol, 0);
      chk("no_strobe_while_busy", busy_viol, 0);
      chk("tx_data_zero_when_idle", idle_viol, 0);
      chk("overrun_single_cycle", ovr_long, 0);
      chk("overrun_total", ovr_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/byte_calc_core.md
Name: byte_calc_core

Overview:
Consumes the host byte stream (receive-strobe interface) as operand A, operand B and an operator character, and computes A+B or A-B. Shows the 5-bit result on the board LEDs and returns the result to the host as ASCII over the transmit-strobe interface. Sits between the UART receive/transmit stages (or the simulation host bench) and the LED pins.

Parameters:
CR_EN, 1, when 1 a 0x0D terminator follows each reply
ERR_CHAR, 8'h3F, reply character for a malformed command ('?')

Ports:
clk12m  input  1  system clock, 12 MHz; sole clock
rst  input  1  synchronous reset, active-high
rx_data  input  8  received byte, valid only while rx_data_rdy=1
rx_data_rdy  input  1  one-cycle strobe, byte available
tx_data  output  8  byte to transmit, valid only while tx_data_rdy=1
tx_data_rdy  output  1  one-cycle strobe, transmit request
tx_busy  input  1  transmitter busy; no tx_data_rdy while high
leds  output  5  leds[4]=carry/borrow, leds[3:0]=result low nibble
rx_overrun  output  1  one-cycle pulse, a byte was dropped

Behaviour:
- One clock (clk12m). Reset is synchronous and active-high; all state is updated on posedge clk12m.
- Reset values: leds=0, tx_data=0, tx_data_rdy=0, rx_overrun=0, state=S_A, operand registers=0.
- States: S_A, S_B, S_OP, S_TX0, S_TX1, S_TXCR, S_ERR.
  - S_A: on rx_data_rdy, if rx_data<=15 latch A=rx_data[3:0] and go to S_B; else go to S_ERR.
  - S_B: same rule, latching B; next state S_OP.
  - S_OP: on rx_data_rdy:
    - rx_data=0x2B ('+'): R={1'b0,A}+{1'b0,B}.
    - rx_data=0x2D ('-'): R={1'b0,A}-{1'b0,B}, 5-bit two's complement, so R[4]=borrow.
    - Either valid operator: leds<=R the next cycle, go to S_TX0.
    - Any other byte: go to S_ERR; leds unchanged.
  - S_TX0: send the ASCII hex digit of R[4] ('0'/'1'), then go to S_TX1.
  - S_TX1: send the uppercase ASCII hex digit of R[3:0] ('0'-'9','A'-'F'), then go to S_TXCR if CR_EN, else S_A.
  - S_TXCR: send 0x0D, then go to S_A.
  - S_ERR: send ERR_CHAR, then go to S_A.
- Transmit rule:
  - A "send" asserts tx_data_rdy for exactly one cycle, with tx_data valid in that cycle, and only in a cycle where tx_busy=0.
  - After each strobe the block waits at least one idle cycle before sampling tx_busy for the next character, so a transmitter that raises tx_busy one cycle late is tolerated.
  - tx_data returns to 0 when tx_data_rdy=0.
- Latency:
  - Operator byte strobed at edge N: leds valid after edge N+1.
  - First tx_data_rdy occurs at edge N+1 at the earliest (tx_busy=0).
  - With tx_busy held low, a reply occupies 2 cycles per character (strobe + gap).
- Bytes arriving in S_TX0/S_TX1/S_TXCR/S_ERR are dropped; rx_overrun pulses high for one cycle, aligned one cycle after the dropped strobe. State and operands are unaffected.
- leds hold the last good result until the next good result or reset. Errors never change leds.
- Back-to-back strobes on consecutive cycles in S_A/S_B/S_OP are each consumed, one byte per cycle.
- Reset mid-command or mid-reply: partial operands are discarded, any pending characters are abandoned, tx_data_rdy is forced low in the reset cycle, and the block returns to S_A.
- rx_data is ignored entirely when rx_data_rdy=0.

Test Plan:
- Bytes 4,3,'+' with tx_busy=0 -> leds=5'b00111; tx strobes 0x30,0x37,0x0D.
- Then 4,4,'+' -> leds=5'b01000, "08\r". Then 4,5,'+' -> leds=5'b01001, "09\r".
- 15,1,'+' -> leds=5'b10000, "10\r". 3,4,'-' -> leds=5'b11111, "1F\r". 9,9,'-' -> leds=0, "00\r".
- Bytes 4,3,'*' -> single 0x3F reply, leds keep their prior value; next 2,2,'+' -> leds=5'b00100. Byte 20 in S_A -> 0x3F, block returns to S_A.
- Hold tx_busy=1 for 50 cycles after 1,1,'+' -> leds update at N+1, no strobe while busy; "02\r" is emitted once tx_busy drops, with at least one idle cycle between strobes. A byte sent during the reply -> rx_overrun pulses once, and the reply is unchanged.
- Assert rst after 7,'+'... (mid-command) and again mid-reply -> all outputs return to 0 next cycle, no further strobes; subsequent 1,2,'+' -> leds=5'b00011, "03\r".
